// File: rtl/tile_pkg.sv
// Shared definitions for the tile grid scanner: geometry, tile encodings,
// FSM states and the default level layout.
package tile_pkg;

  localparam int TILE_X_BITS   = 6;
  localparam int TILE_Y_BITS   = 5;
  localparam int MAP_ADDR_BITS = 8;

  localparam logic [10:0] GRID_COLS = 11'd10;
  localparam logic [10:0] GRID_ROWS = 11'd15;

  localparam logic [1:0] TILE_BACKGROUND = 2'b00;
  localparam logic [1:0] TILE_FLOOR      = 2'b01;
  localparam logic [1:0] TILE_GIFT       = 2'b10;

  typedef enum logic [2:0] {
    INIT,
    RUN,
    COL_READ,
    COL_WRITE,
    COL_ACK
  } scan_state_t;

  function automatic logic [1:0] default_tile(input logic [3:0] row, input logic [3:0] col);
    logic [1:0] t;
    t = TILE_BACKGROUND;
    if (row == 4'd14)
      t = TILE_FLOOR;
    else if (row == 4'd9 && col >= 4'd2 && col <= 4'd7)
      t = TILE_FLOOR;
    else if ((row == 4'd8 && (col == 4'd3 || col == 4'd6)) ||
             (row == 4'd13 && (col == 4'd1 || col == 4'd8)))
      t = TILE_GIFT;
    return t;
  endfunction

endpackage

// File: rtl/tile_grid_scanner_map_ram.sv
// 256x2 tile-type store: one synchronous write port and two independent
// combinational read ports (display and collect). Contents are not reset.
module tile_map_ram
  import tile_pkg::*;
(
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [MAP_ADDR_BITS-1:0] wr_addr,
  input  logic [1:0]               wr_data,
  input  logic [MAP_ADDR_BITS-1:0] rd_a_addr,
  output logic [1:0]               rd_a_data,
  input  logic [MAP_ADDR_BITS-1:0] rd_b_addr,
  output logic [1:0]               rd_b_data
);

  logic [1:0] mem [0:(1<<MAP_ADDR_BITS)-1];

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
  end

  assign rd_a_data = mem[rd_a_addr];
  assign rd_b_data = mem[rd_b_addr];

endmodule

// File: rtl/tile_grid_scanner.sv
// Maps the raster pixel to its 64x32 tile cell and type for the drawer, loads
// the level layout after reset and services gift-collect requests.
module tile_grid_scanner
  import tile_pkg::*;
(
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic [1:0]  Tile_type,
  output logic        tileValid,
  input  logic        collectReq,
  input  logic [10:0] collectX,
  input  logic [10:0] collectY,
  output logic        collectAck,
  output logic        giftCollected,
  output logic [7:0]  giftsRemaining,
  output logic        levelClear,
  output logic        initBusy
);

  scan_state_t state, state_nxt;

  logic [7:0]  init_cnt;
  logic [7:0]  gifts;
  logic        gift_flag;
  logic [7:0]  coll_addr;
  logic        coll_in_range;
  logic [1:0]  coll_type;
  logic        coll_hit;

  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [1:0]  wr_data;
  logic [1:0]  disp_type_p0;
  logic [1:0]  coll_rd;

  logic [10:0] ccol;
  logic [10:0] crow;

  // Stage p0: cell coordinates and map lookup straight from the raster position
  logic [10:0] col_p0;
  logic [10:0] row_p0;
  logic [7:0]  addr_p0;
  logic        vld_p0;

  assign col_p0  = pixelX >> TILE_X_BITS;
  assign row_p0  = pixelY >> TILE_Y_BITS;
  assign addr_p0 = {row_p0[3:0], col_p0[3:0]};
  assign vld_p0  = (col_p0 < GRID_COLS) && (row_p0 < GRID_ROWS) && !initBusy;

  assign ccol = collectX >> TILE_X_BITS;
  assign crow = collectY >> TILE_Y_BITS;

  tile_map_ram u_map (
    .clk       (clk),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_a_addr (addr_p0),
    .rd_a_data (disp_type_p0),
    .rd_b_addr (coll_addr),
    .rd_b_data (coll_rd)
  );

  // Stage p1: registered drawer interface
  logic [10:0] offset_x_p1;
  logic [10:0] offset_y_p1;
  logic [1:0]  tile_type_p1;
  logic        vld_p1;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      offset_x_p1  <= '0;
      offset_y_p1  <= '0;
      tile_type_p1 <= TILE_BACKGROUND;
      vld_p1       <= 1'b0;
    end else begin
      offset_x_p1  <= {{(11-TILE_X_BITS){1'b0}}, pixelX[TILE_X_BITS-1:0]};
      offset_y_p1  <= {{(11-TILE_Y_BITS){1'b0}}, pixelY[TILE_Y_BITS-1:0]};
      tile_type_p1 <= vld_p0 ? disp_type_p0 : TILE_BACKGROUND;
      vld_p1       <= vld_p0;
    end
  end

  assign offsetX   = offset_x_p1;
  assign offsetY   = offset_y_p1;
  assign Tile_type = tile_type_p1;
  assign tileValid = vld_p1;

  assign coll_hit = coll_in_range && (coll_type == TILE_GIFT);

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_addr   = init_cnt;
    wr_data   = default_tile(init_cnt[7:4], init_cnt[3:0]);
    case (state)
      INIT: begin
        wr_en = 1'b1;
        if (init_cnt == 8'hFF)
          state_nxt = RUN;
      end
      RUN: begin
        if (collectReq)
          state_nxt = COL_READ;
      end
      COL_READ: state_nxt = COL_WRITE;
      COL_WRITE: begin
        wr_addr   = coll_addr;
        wr_data   = TILE_BACKGROUND;
        wr_en     = coll_hit;
        state_nxt = COL_ACK;
      end
      COL_ACK: state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= INIT;
      init_cnt  <= '0;
      gifts     <= '0;
      gift_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == INIT) begin
        init_cnt <= init_cnt + 8'd1;
        if (wr_data == TILE_GIFT && gifts != 8'hFF)
          gifts <= gifts + 8'd1;
      end
      if (state == COL_WRITE) begin
        gift_flag <= coll_hit;
        // Count never wraps below zero even if the map and count disagree
        if (coll_hit && gifts != 8'd0)
          gifts <= gifts - 8'd1;
      end
    end
  end

  // Collect cell latch and second-port read; only consumed after being loaded
  always_ff @(posedge clk) begin
    if (state == RUN && collectReq) begin
      coll_addr     <= {crow[3:0], ccol[3:0]};
      coll_in_range <= (ccol < GRID_COLS) && (crow < GRID_ROWS);
    end
    if (state == COL_READ)
      coll_type <= coll_rd;
  end

  assign initBusy       = (state == INIT);
  assign collectAck     = (state == COL_ACK);
  assign giftCollected  = (state == COL_ACK) && gift_flag;
  assign giftsRemaining = gifts;
  assign levelClear     = (gifts == 8'd0) && !initBusy;

endmodule

// File: tb/tb_tile_grid_scanner.sv
// Self-checking bench for tile_grid_scanner against a cell-array model of the level.
module tb_tile_grid_scanner;

  logic        clk = 1'b0;
  logic        resetN;
  logic [10:0] pixelX, pixelY;
  logic [10:0] offsetX, offsetY;
  logic [1:0]  Tile_type;
  logic        tileValid;
  logic        collectReq;
  logic [10:0] collectX, collectY;
  logic        collectAck, giftCollected, levelClear, initBusy;
  logic [7:0]  giftsRemaining;

  int n_checks = 0;
  int n_fail   = 0;

  int mdl [0:255];
  int gifts_m;

  tile_grid_scanner dut (
    .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
    .offsetX(offsetX), .offsetY(offsetY), .Tile_type(Tile_type), .tileValid(tileValid),
    .collectReq(collectReq), .collectX(collectX), .collectY(collectY),
    .collectAck(collectAck), .giftCollected(giftCollected),
    .giftsRemaining(giftsRemaining), .levelClear(levelClear), .initBusy(initBusy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_tile(input int r, input int c);
    if (r == 14) return 1;
    if (r == 9 && c >= 2 && c <= 7) return 1;
    if ((r == 8 && c == 3) || (r == 8 && c == 6) || (r == 13 && c == 1) || (r == 13 && c == 8))
      return 2;
    return 0;
  endfunction

  task automatic load_model();
    gifts_m = 0;
    for (int a = 0; a < 256; a++) begin
      mdl[a] = ref_tile(a / 16, a % 16);
      if (mdl[a] == 2) gifts_m++;
    end
  endtask

  // Called right after resetN is released; counts edges until the layout is loaded
  task automatic wait_init();
    int cnt;
    cnt = 0;
    pixelX = 11'd200;
    pixelY = 11'd270;
    do begin
      tick();
      cnt++;
      if (cnt == 100) check("valid_during_init", tileValid, 0);
    end while (initBusy && cnt < 400);
    check("init_cycles", cnt, 256);
    check("init_gifts", giftsRemaining, gifts_m);
    check("init_levelclear", levelClear, 0);
  endtask

  task automatic disp(input int x, input int y);
    int c, r, et, ev;
    pixelX = x[10:0];
    pixelY = y[10:0];
    c = x / 64;
    r = y / 32;
    ev = (c < 10 && r < 15) ? 1 : 0;
    et = ev ? mdl[r * 16 + c] : 0;
    tick();
    check("offsetX", offsetX, x % 64);
    check("offsetY", offsetY, y % 32);
    check("tileValid", tileValid, ev);
    check("Tile_type", Tile_type, et);
  endtask

  task automatic collect(input int x, input int y);
    int c, r, k, eg;
    c = x / 64;
    r = y / 32;
    eg = 0;
    if (c < 10 && r < 15) begin
      if (mdl[r * 16 + c] == 2) begin
        eg = 1;
        mdl[r * 16 + c] = 0;
        if (gifts_m > 0) gifts_m--;
      end
    end
    collectX = x[10:0];
    collectY = y[10:0];
    collectReq = 1'b1;
    k = 0;
    do begin
      tick();
      k++;
    end while (!collectAck && k < 10);
    collectReq = 1'b0;
    check("collect_latency", k, 3);
    check("collect_ack", collectAck, 1);
    check("gift_collected", giftCollected, eg);
    check("gifts_remaining", giftsRemaining, gifts_m);
    tick();
    check("ack_one_cycle", collectAck, 0);
    check("levelclear", levelClear, (gifts_m == 0) ? 1 : 0);
  endtask

  initial begin
    int gx [4];
    int gy [4];
    gx = '{3, 6, 1, 8};
    gy = '{8, 8, 13, 13};
    resetN = 1'b0;
    pixelX = '0;
    pixelY = '0;
    collectReq = 1'b0;
    collectX = '0;
    collectY = '0;
    repeat (3) tick();
    check("rst_initBusy", initBusy, 1);
    check("rst_gifts", giftsRemaining, 0);
    check("rst_ack", collectAck, 0);
    check("rst_giftcol", giftCollected, 0);
    check("rst_levelclear", levelClear, 0);
    check("rst_valid", tileValid, 0);
    check("rst_type", Tile_type, 0);
    check("rst_offx", offsetX, 0);
    check("rst_offy", offsetY, 0);

    load_model();
    resetN = 1'b1;
    wait_init();
    check("run_initBusy", initBusy, 0);

    disp(200, 270);
    disp(639, 479);
    disp(650, 100);
    disp(0, 0);
    disp(640, 479);
    disp(639, 480);

    collect(70, 420);
    disp(70, 420);
    collect(70, 420);
    collect(10, 10);
    collect(700, 100);

    for (int i = 0; i < 40; i++)
      disp($urandom_range(0, 2047), $urandom_range(0, 2047));
    for (int i = 0; i < 6; i++)
      collect($urandom_range(0, 760), $urandom_range(0, 540));
    for (int i = 0; i < 30; i++)
      disp($urandom_range(0, 700), $urandom_range(0, 520));

    for (int i = 0; i < 4; i++)
      collect(gx[i] * 64 + $urandom_range(0, 63), gy[i] * 32 + $urandom_range(0, 31));
    check("all_gifts_gone", giftsRemaining, 0);
    check("level_clear", levelClear, 1);
    collect(200, 270);
    check("no_wrap", giftsRemaining, 0);

    // Reset while the FSM is in COL_WRITE
    collectX = 11'd70;
    collectY = 11'd420;
    collectReq = 1'b1;
    tick();
    tick();
    resetN = 1'b0;
    collectReq = 1'b0;
    #1;
    check("midreset_initBusy", initBusy, 1);
    check("midreset_ack", collectAck, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("midreset_no_ack", collectAck, 0);
    end
    load_model();
    resetN = 1'b1;
    wait_init();
    check("reload_gifts", giftsRemaining, 4);
    disp(70, 420);
    check("gift_restored", Tile_type, 2);
    for (int i = 0; i < 10; i++)
      disp($urandom_range(0, 700), $urandom_range(0, 520));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tile_grid_scanner.md
Name: tile_grid_scanner

Overview:
- Front end feeding the per-tile bitmap drawer.
- Takes the VGA raster pixel coordinate, finds which 64x32 tile cell it falls in, and looks up that cell's type in an internal tile-type map.
- Drives offsetX/offsetY/Tile_type, registered, to the drawer.
- Owns the level layout: loads it after reset, accepts "collect" requests from game logic to clear gift tiles, and tracks the number of gifts remaining.

Parameters:
- TILE_X_BITS, 6, log2 tile width (64 px)
- TILE_Y_BITS, 5, log2 tile height (32 px)
- GRID_COLS, 10, visible tile columns (640/64)
- GRID_ROWS, 15, visible tile rows (480/32)
- MAP_ADDR_BITS, 8, map storage is 16x16 cells, address = {row[3:0], col[3:0]}

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- pixelX  in  11  current raster X
- pixelY  in  11  current raster Y
- offsetX  out  11  X offset inside tile, zero-extended pixelX[TILE_X_BITS-1:0]
- offsetY  out  11  Y offset inside tile, zero-extended pixelY[TILE_Y_BITS-1:0]
- Tile_type  out  2  00 background, 01 floor, 10 gift, 11 reserved
- tileValid  out  1  pixel lies inside the GRID_COLS x GRID_ROWS area and the map is initialised
- collectReq  in  1  level request to collect the tile at (collectX, collectY)
- collectX  in  11  pixel X of the collect point
- collectY  in  11  pixel Y of the collect point
- collectAck  out  1  one-cycle completion pulse
- giftCollected  out  1  one-cycle pulse, coincident with collectAck, when a gift was removed
- giftsRemaining  out  8  number of gift tiles in the map
- levelClear  out  1  high when giftsRemaining==0 and not initialising
- initBusy  out  1  high during layout load

Behaviour:
- Reset: clk and resetN as already decided (resetN asynchronous, active-low).
- Reset values: all outputs 0 except initBusy=1; FSM enters INIT; giftsRemaining=0.
- Display path, latency 1 cycle. pixel (X,Y) sampled at edge N produces offsetX/offsetY/Tile_type/tileValid valid after edge N.
- col = pixelX>>TILE_X_BITS and row = pixelY>>TILE_Y_BITS, both computed on the full 11 bits.
- If col>=GRID_COLS or row>=GRID_ROWS, or initBusy=1: Tile_type=00 and tileValid=0. Offsets are still driven.
- FSM states: INIT, RUN, COL_READ, COL_WRITE, COL_ACK.
- INIT
  - An 8-bit counter sweeps addresses 0..255, one write per cycle, loading the default layout.
  - Row 14 (all columns): floor.
  - Row 9, columns 2..7: floor.
  - Gifts at (row 8, col 3), (8, 6), (13, 1), (13, 8).
  - All other cells: background.
  - Each gift write increments giftsRemaining, so it ends at 4.
  - After address 255 is written, go to RUN (256 cycles); initBusy drops on the same edge.
- RUN: if collectReq=1, latch the collect cell (col/row from collectX/collectY) and go to COL_READ. Requests during INIT are held off and not lost, since collectReq is level-sensitive.
- COL_READ: read the map at the latched cell on a second, independent read port, so the display path is never stalled. Go to COL_WRITE.
- COL_WRITE
  - If the cell is in range and its type is gift: write 00, decrement giftsRemaining, set an internal gift flag.
  - Otherwise: no write.
  - Go to COL_ACK.
- COL_ACK: collectAck=1 for exactly one cycle; giftCollected = gift flag. Return to RUN.
  - collectAck therefore comes 3 cycles after collectReq is first sampled in RUN.
- Requester handshake: the requester must deassert collectReq in the cycle after collectAck. If it is still high in RUN, it is treated as a new request; a second collect of the same cell acks with giftCollected=0.
- Display read and collect write to the same cell in the same cycle: the display reads the old value; the new value is visible from the next cycle.
- giftsRemaining saturates at 0 and never wraps.
- Reset mid-collect or mid-INIT: the FSM aborts, collectAck is not issued, and INIT restarts the layout load.

Decomposition:
- Package tile_pkg holds:
  - tile type encodings TILE_BACKGROUND, TILE_FLOOR, TILE_GIFT
  - TILE_X_BITS, TILE_Y_BITS, GRID_COLS, GRID_ROWS
  - a function default_tile(row, col) returning the layout
  - the FSM state enum
- Sub-module tile_map_ram: 256x2 register array with two combinational read ports and one synchronous write port. It has no reset; INIT overwrites every cell.

Test Plan:
- Reset, then run 256 cycles: initBusy falls after cycle 256, giftsRemaining=4, levelClear=0. Pixel (200,270) → next cycle Tile_type=10, offsetX=8, offsetY=14, tileValid=1.
- Pixel (639,479) → Tile_type=01, offsetX=63, offsetY=31. Pixel (650,100) → tileValid=0, Tile_type=00.
- collectReq with (70,420), which is gift (13,1): collectAck 3 cycles later with giftCollected=1, giftsRemaining=3. Pixel (70,420) afterwards → Tile_type=00.
- Collect the same point again: ack with giftCollected=0, giftsRemaining stays 3. Collect (10,10), a background cell: ack, no change.
- Collect all four gifts: giftsRemaining=0, levelClear=1. A further collect leaves giftsRemaining at 0 (no wrap).
- Assert resetN=0 during COL_WRITE: no ack, initBusy=1. After 256 cycles giftsRemaining=4 and the gift at (13,1) is restored.
